// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin, burst-limited owner selection for a
// 2:1 data mux, feeding a single-entry registered valid/ready output stage.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [WIDTH-1:0] Input0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Input1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Sel,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Output_Mux
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [4:0] LP_MAX = 5'(MAX_BURST);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    logic             w_slot_free;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer_own;
    logic             w_req_own;
    logic             w_req_oth;
    logic [4:0]       w_cnt_p;
    logic             w_hit;
    logic [WIDTH-1:0] w_mux;

    assign w_slot_free = !r_valid | Out_Ready;
    assign Gnt0        = (r_state == OWN0) & w_slot_free;
    assign Gnt1        = (r_state == OWN1) & w_slot_free;
    assign Sel         = (r_state == OWN1);
    assign w_xfer0     = Gnt0 & Req0;
    assign w_xfer1     = Gnt1 & Req1;
    assign w_xfer_own  = w_xfer0 | w_xfer1;
    assign w_req_own   = Sel ? Req1 : Req0;
    assign w_req_oth   = Sel ? Req0 : Req1;
    assign w_cnt_p     = {1'b0, r_cnt} + {4'd0, w_xfer_own};
    assign w_hit       = (w_cnt_p == LP_MAX);
    assign w_mux       = Sel ? Input1 : Input0;
    assign Out_Valid   = r_valid;
    assign Output_Mux  = r_data;

    // Ownership state, round-robin pointer and burst counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next owner: tie in IDLE goes to the side not served last; an owner
    // yields when it stops asking or when its burst is used up under contention
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (Req0 & Req1)
                    w_state_nxt = r_last ? OWN0 : OWN1;
                else if (Req0)
                    w_state_nxt = OWN0;
                else if (Req1)
                    w_state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (!w_req_own | (w_req_oth & w_hit)) begin
                    if (w_req_oth)
                        w_state_nxt = Sel ? OWN0 : OWN1;
                    else
                        w_state_nxt = IDLE;
                    w_last_nxt = Sel;
                    w_cnt_nxt  = 4'd0;
                end else if (w_hit) begin
                    w_cnt_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = w_cnt_p[3:0];
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Single-entry output stage: load on transfer, empty on consume
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_xfer_own) begin
            r_valid <= 1'b1;
            r_data  <= w_mux;
        end else if (r_valid & Out_Ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed vectors with hand-computed expectations for
// the round-robin mux arbiter (MAX_BURST = 4).
module tb_mux2_rr_arbiter;

    localparam logic [31:0] A = 32'h12345678;
    localparam logic [31:0] B = 32'hFEDCBA98;

    logic        Clk;
    logic        Reset;
    logic        Req0;
    logic [31:0] Input0;
    logic        Req1;
    logic [31:0] Input1;
    logic        Gnt0;
    logic        Gnt1;
    logic        Sel;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Output_Mux;

    int n_checks = 0;
    int n_errors = 0;

    mux2_rr_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0       (Req0),
        .Input0     (Input0),
        .Req1       (Req1),
        .Input1     (Input1),
        .Gnt0       (Gnt0),
        .Gnt1       (Gnt1),
        .Sel        (Sel),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Output_Mux (Output_Mux)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_s;
        Reset     = 1'b0;
        Req0      = 1'b0;
        Req1      = 1'b0;
        Input0    = A;
        Input1    = B;
        Out_Ready = 1'b1;
        #2 Reset = 1'b1;
        #1;
        chk("rst_gnt0", {31'd0, Gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, Gnt1}, 32'd0);
        chk("rst_sel", {31'd0, Sel}, 32'd0);
        chk("rst_valid", {31'd0, Out_Valid}, 32'd0);
        chk("rst_data", Output_Mux, 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("idle_gnt0", {31'd0, Gnt0}, 32'd0);

        // tie from IDLE after reset goes to requester 0
        Req0 = 1'b1;
        Req1 = 1'b1;
        tick();
        chk("tie_sel", {31'd0, Sel}, 32'd0);
        chk("tie_gnt0", {31'd0, Gnt0}, 32'd1);
        chk("tie_gnt1", {31'd0, Gnt1}, 32'd0);
        chk("tie_valid", {31'd0, Out_Valid}, 32'd0);
        // 4 words each, alternating, no bubbles
        for (int k = 2; k <= 17; k++) begin
            tick();
            exp_d = ((((k - 2) / 4) % 2) == 0) ? A : B;
            exp_s = ((((k - 1) / 4) % 2) == 1);
            chk($sformatf("rr_data_%0d", k), Output_Mux, exp_d);
            chk($sformatf("rr_valid_%0d", k), {31'd0, Out_Valid}, 32'd1);
            chk($sformatf("rr_sel_%0d", k), {31'd0, Sel}, {31'd0, exp_s});
        end

        // backpressure: owner 0, Cnt 0, holding B
        Out_Ready = 1'b0;
        #1;
        chk("bp_gnt0", {31'd0, Gnt0}, 32'd0);
        chk("bp_gnt1", {31'd0, Gnt1}, 32'd0);
        tick();
        tick();
        chk("bp_data", Output_Mux, B);
        chk("bp_valid", {31'd0, Out_Valid}, 32'd1);
        chk("bp_sel", {31'd0, Sel}, 32'd0);
        Out_Ready = 1'b1;
        #1;
        chk("bp_rel_gnt0", {31'd0, Gnt0}, 32'd1);
        tick();
        chk("bp_rel_data", Output_Mux, A);
        tick();
        tick();
        tick();
        chk("bp_burst4", Output_Mux, A);
        tick();
        chk("bp_switch", Output_Mux, B);
        chk("bp_switch_sel", {31'd0, Sel}, 32'd1);

        // owner 1 drops its request while granted
        Req1 = 1'b0;
        #1;
        chk("drop_gnt1", {31'd0, Gnt1}, 32'd1);
        tick();
        chk("drop_valid", {31'd0, Out_Valid}, 32'd0);
        chk("drop_data", Output_Mux, B);
        chk("drop_sel", {31'd0, Sel}, 32'd0);
        chk("drop_gnt0", {31'd0, Gnt0}, 32'd1);
        tick();
        chk("drop_next_data", Output_Mux, A);
        chk("drop_next_valid", {31'd0, Out_Valid}, 32'd1);

        // back to IDLE with Last=0, then a tie goes to requester 1
        Req0 = 1'b0;
        tick();
        chk("idle2_gnt0", {31'd0, Gnt0}, 32'd0);
        chk("idle2_gnt1", {31'd0, Gnt1}, 32'd0);
        chk("idle2_valid", {31'd0, Out_Valid}, 32'd0);
        Req0 = 1'b1;
        Req1 = 1'b1;
        tick();
        chk("tie2_sel", {31'd0, Sel}, 32'd1);
        chk("tie2_gnt1", {31'd0, Gnt1}, 32'd1);
        tick();
        chk("tie2_data", Output_Mux, B);
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
        chk("idle3_sel", {31'd0, Sel}, 32'd0);
        chk("idle3_valid", {31'd0, Out_Valid}, 32'd0);

        // single requester: 2-edge latency
        Req0 = 1'b1;
        tick();
        chk("single_gnt0", {31'd0, Gnt0}, 32'd1);
        chk("single_sel", {31'd0, Sel}, 32'd0);
        chk("single_valid0", {31'd0, Out_Valid}, 32'd0);
        tick();
        chk("single_data", Output_Mux, A);
        chk("single_valid", {31'd0, Out_Valid}, 32'd1);

        // asynchronous reset mid-burst
        #2 Reset = 1'b1;
        #1;
        chk("mrst_gnt0", {31'd0, Gnt0}, 32'd0);
        chk("mrst_sel", {31'd0, Sel}, 32'd0);
        chk("mrst_valid", {31'd0, Out_Valid}, 32'd0);
        chk("mrst_data", Output_Mux, 32'd0);
        tick();
        Reset = 1'b0;
        Req1  = 1'b1;
        tick();
        chk("mrst_tie_gnt0", {31'd0, Gnt0}, 32'd1);
        chk("mrst_tie_gnt1", {31'd0, Gnt1}, 32'd0);
        tick();
        chk("mrst_tie_data", Output_Mux, A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and sequencer for the 32-bit 2:1 mux datapath. Two requesters each present a data word with a request. The block drives the mux `Sel` so each requester gets fair, burst-limited ownership, and registers the selected word into a single-entry output stage with a valid/ready handshake toward the consumer.

## Interface
- `WIDTH`, 32: data width of `Input0`, `Input1` and `Output_Mux`.
- `MAX_BURST`, 4: maximum consecutive transfers by one owner while the other requester is waiting. Legal range is 1..15.
- `Clk`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Req0`, in, 1: requester 0 has a word on `Input0`. It must hold `Req0` and `Input0` stable until its transfer cycle.
- `Input0`, in, WIDTH: requester 0 data.
- `Req1`, in, 1: requester 1 request, with the same rules as `Req0`.
- `Input1`, in, WIDTH: requester 1 data.
- `Gnt0`, out, 1: requester 0 may transfer this cycle. Combinational.
- `Gnt1`, out, 1: requester 1 may transfer this cycle. Combinational.
- `Sel`, out, 1: mux select. 0 selects `Input0`, 1 selects `Input1`.
- `Out_Valid`, out, 1: `Output_Mux` holds an unconsumed word.
- `Out_Ready`, in, 1: consumer accepts the word this cycle.
- `Output_Mux`, out, WIDTH: registered selected word.

## Operation
- **States:** IDLE, OWN0, OWN1. Also held: a `Last` pointer (1 bit) and a burst counter `Cnt` (4 bits).
- **Output stage:**
  - `Slot_Free` = !Out_Valid | Out_Ready.
  - `Gnt0` = (state==OWN0) & Slot_Free.
  - `Gnt1` = (state==OWN1) & Slot_Free.
  - `Xfer_i` = Gnt_i & Req_i.
- **Sel:** 1 in OWN1. 0 in IDLE and OWN0.
- **Data capture:** on `Xfer_i`, `Output_Mux` <= the mux output (`Input_i`) and `Out_Valid` <= 1.
  - If there is no transfer and Out_Valid & Out_Ready, then `Out_Valid` <= 0 and `Output_Mux` holds its value.
- **IDLE:**
  - Req0 & !Req1 → OWN0.
  - Req1 & !Req0 → OWN1.
  - Both requesting → OWN0 if Last==1, else OWN1.
  - Neither requesting → stay in IDLE.
- **OWNi (j = other requester):**
  - Let `Cnt'` = Cnt + Xfer_i.
  - Leave ownership when !Req_i, or when Req_j & Cnt'==MAX_BURST.
  - On leaving: go to OWNj if Req_j, else IDLE. Set `Last` <= i and `Cnt` <= 0.
  - Otherwise stay in OWNi.
    - If Cnt'==MAX_BURST (only possible with Req_j low), `Cnt` <= 0.
    - Else `Cnt` <= Cnt'.
- **Simultaneous events:** a transfer and the ownership change happen at the same edge. The last word of the old owner is captured and the new owner is granted from the next cycle.
- **Req_i dropped while granted:** no transfer occurs; the state leaves OWNi at that edge.
- **Out_Ready low with Out_Valid high:** both grants are 0. State, `Cnt` and `Output_Mux` hold. Ownership can still change if the owner drops its request.
- **Reset (asserted at any time):** immediately forces IDLE, Last=1, Cnt=0, Out_Valid=0, Output_Mux=0, Sel=0, Gnt0=Gnt1=0. Any word in flight is discarded.

## Timing
- **Reset values:** Gnt0=0, Gnt1=0, Sel=0, Out_Valid=0, Output_Mux=32'h00000000.
- **Latency from IDLE:** Req sampled at edge E1 → OWN state after E1. Gnt is high in the cycle after E1. Transfer at E2, and Output_Mux/Out_Valid are valid after E2. Total: 2 edges.
- **Throughput:** one word per cycle while Out_Ready=1 and the owner keeps requesting.
- **Handover:** no bubble cycle between owners.
- **Backpressure:** the handshake depends on Out_Ready combinationally through `Slot_Free`. There is no skid buffer.
- **Fairness:** with both requesters held high and MAX_BURST=4, grants repeat 4×req0, then 4×req1, and so on.

## Test plan
1. **Reset:** assert Reset mid-burst → all outputs take their reset values in the same cycle. After release, state is IDLE.
2. **Single requester:** Req0=1, Input0=32'h12345678, Out_Ready=1 → Sel=0, Output_Mux=32'h12345678 with Out_Valid=1 two edges after Req0 is sampled.
3. **Contention, no backpressure:** Req0=Req1=1, Input0=32'h12345678, Input1=32'hFEDCBA98, Out_Ready=1, MAX_BURST=4 → transfers 4×12345678 then 4×FEDCBA98, repeating. Sel toggles every 4 words with no empty cycle.
4. **Backpressure:** Out_Ready=0 with Out_Valid=1 → Gnt0=Gnt1=0, Output_Mux held, Cnt unchanged. Raise Out_Ready → the next word is accepted in the same cycle.
5. **Drop request:** while in OWN1, Req1 falls with Req0=1 → no transfer that cycle, state moves to OWN0, Sel=0 next cycle.
6. **Tie after idle:** both requesters raised together from IDLE after reset → OWN0 first (Last=1). After req0's burst ends, a later tie goes to OWN1.
